// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the binary-to-BCD display feeder.
// Digit codes match the seven-segment scan stage (A = dash, B = blank).
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FMT   = 2'd2
  } conv_state_e;

  localparam logic [3:0] DIG_DASH    = 4'hA;
  localparam logic [3:0] DIG_BLANK   = 4'hB;
  localparam int         DISP_DIGITS = 4;
  localparam int         DEF_MAX_VAL = 9999;

  // Replace leading zero digits 3..1 with blanks; digit 0 always stays visible.
  function automatic logic [15:0] blank_lead(input logic [15:0] digits);
    logic [15:0] res;
    logic        lead;
    res  = digits;
    lead = 1'b1;
    for (int i = DISP_DIGITS - 1; i >= 1; i--) begin
      if (lead && (digits[i*4 +: 4] == 4'h0)) begin
        res[i*4 +: 4] = DIG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_disp_if.sv
// Request/response bundle between a value producer and the BCD display feeder.
interface bin2bcd_disp_if #(
  parameter int BIN_W = 14
) ();

  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [15:0]      dataBus;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  dataBus
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output dataBus
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  assign q_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin2bcd_disp.sv
// Iterative binary-to-BCD converter feeding the 4-digit scan stage.
// Define LEAD_BLANK_EN to blank leading zero digits of non-overflow results.
module bin2bcd_disp
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic                 clk,
  input  logic                 rst,
  bin2bcd_disp_if.slave        bus_if
);

  localparam int               CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [BIN_W-1:0] bin_q,   bin_d;
  logic [15:0]      bcd_q,   bcd_d;
  logic             ovf_q,   ovf_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [15:0]      data_q,  data_d;

  logic [15:0]      bcd_adj_s;
  logic [15:0]      fmt_s;

  for (genvar g = 0; g < DISP_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[g*4 +: 4]),
      .q_o (bcd_adj_s[g*4 +: 4])
    );
  end

`ifdef LEAD_BLANK_EN
  assign fmt_s = blank_lead(bcd_q);
`else
  assign fmt_s = bcd_q;
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  // Next-state and datapath logic; done is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          bin_d   = bus_if.bin_in;
          bcd_d   = 16'h0000;
          ovf_d   = (32'(bus_if.bin_in) > 32'(MAX_VAL));
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj_s[14:0], bin_q, 1'b0};
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FMT;
        end else begin
          state_d = SHIFT;
        end
      end
      FMT: begin
        if (ovf_q) begin
          data_d = {DIG_DASH, DIG_DASH, DIG_DASH, DIG_DASH};
        end else begin
          data_d = fmt_s;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_if.busy    = busy_q;
  assign bus_if.done    = done_q;
  assign bus_if.dataBus = data_q;

endmodule
